// File: rtl/mem_wb_stage_pkg.sv
// Shared core definitions: ALU select codes, writeback selects, load/store funct3 codes, W-register layout.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mem_wb_stage_pkg;

    // ALU operation select codes used by the execute stage.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_sel_t;

    // Writeback source selects.
    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;

    // Load funct3 codes.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 codes (only the low two bits carry the access size).
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access size encoded in funct3[1:0].
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    // Memory/writeback pipeline register contents.
    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        reg_we;
        logic [1:0]  wb_sel;
        logic [2:0]  funct3;
        logic [31:0] alu_out;
        logic [31:0] pc_plus4;
        logic        mis;
    } w_reg_t;

    // True when the access size in funct3 is not naturally aligned at the byte offset.
    function automatic logic access_is_misaligned(input logic [2:0] funct3,
                                                  input logic [1:0] offset);
        logic bad;
        case (funct3[1:0])
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            default:   bad = (offset != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Selects and extends the addressed byte/halfword/word out of a 32-bit memory word.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module load_extract
    import mem_wb_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Pick the addressed byte and halfword lane; halfwords use offset[1] only.
    always_comb begin
        case (offset)
            2'd0:    sel_byte = word[7:0];
            2'd1:    sel_byte = word[15:8];
            2'd2:    sel_byte = word[23:16];
            default: sel_byte = word[31:24];
        endcase
        sel_half = offset[1] ? word[31:16] : word[15:0];
    end

    // Sign- or zero-extend according to the load type; unknown codes pass the word through.
    always_comb begin
        case (funct3)
            F3_LB:   result = {{24{sel_byte[7]}}, sel_byte};
            F3_LH:   result = {{16{sel_half[15]}}, sel_half};
            F3_LW:   result = word;
            F3_LBU:  result = {24'd0, sel_byte};
            F3_LHU:  result = {16'd0, sel_half};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access + writeback stage: issues data-memory requests and selects the register writeback value (MISALIGN_FLAG_EN adds misalignment trapping).
// Latency: memory request in the input cycle; writeback one cycle later from the W register.
// Backpressure: stall holds W and suppresses requests; flush kills the incoming instruction.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DMEM_AW = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               stall,
    input  logic               flush,
    input  logic [31:0]        alu_out,
    input  logic [31:0]        rs2_data,
    input  logic [31:0]        pc_plus4,
    input  logic [4:0]         rd,
    input  logic               reg_we,
    input  logic               mem_rd,
    input  logic               mem_wr,
    input  logic [2:0]         funct3,
    input  logic [1:0]         wb_sel,
    output logic               dmem_en,
    output logic [3:0]         dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_din,
    input  logic [31:0]        dmem_dout,
    output logic               wb_we,
    output logic [4:0]         wb_rd,
`ifdef MISALIGN_FLAG_EN
    output logic               misalign,
`endif
    output logic [31:0]        wb_data
);

    w_reg_t      w_q;
    w_reg_t      w_cap;
    logic        go;
    logic        mis_now;
    logic [31:0] load_val;

    // Reset is folded in so a store in flight when rst rises is dropped without waiting for a clock.
    assign go = in_valid & ~stall & ~flush & ~rst;

`ifdef MISALIGN_FLAG_EN
    assign mis_now = (mem_rd | mem_wr) & access_is_misaligned(funct3, alu_out[1:0]);
`else
    assign mis_now = 1'b0;
`endif

    assign dmem_addr = alu_out[DMEM_AW+1:2];

    // Memory request: enable, byte-lane write mask and lane-aligned store data.
    always_comb begin
        dmem_en = go & (mem_rd | mem_wr) & ~mis_now;
        dmem_we = 4'b0000;
        if (dmem_en & mem_wr) begin
            case (funct3[1:0])
                SIZE_BYTE: dmem_we = 4'b0001 << alu_out[1:0];
                SIZE_HALF: dmem_we = 4'b0011 << {alu_out[1], 1'b0};
                default:   dmem_we = 4'b1111;
            endcase
        end
        case (funct3[1:0])
            SIZE_BYTE: dmem_din = rs2_data << {alu_out[1:0], 3'b000};
            SIZE_HALF: dmem_din = rs2_data << {alu_out[1], 4'b0000};
            default:   dmem_din = rs2_data;
        endcase
    end

    // Value the W register takes when an instruction is accepted.
    always_comb begin
        w_cap          = '0;
        w_cap.valid    = 1'b1;
        w_cap.rd       = rd;
        w_cap.reg_we   = reg_we;
        w_cap.wb_sel   = wb_sel;
        w_cap.funct3   = funct3;
        w_cap.alu_out  = alu_out;
        w_cap.pc_plus4 = pc_plus4;
        w_cap.mis      = mis_now;
    end

    // W register: flush wins over stall, stall holds everything, idle cycles drop valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q <= '0;
        end else if (flush) begin
            w_q.valid <= 1'b0;
        end else if (!stall) begin
            if (in_valid) begin
                w_q <= w_cap;
            end else begin
                w_q.valid <= 1'b0;
            end
        end
    end

    // Load data arrives one cycle after the request, aligned with the instruction now in W.
    load_extract u_load_extract (
        .funct3 (w_q.funct3),
        .offset (w_q.alu_out[1:0]),
        .word   (dmem_dout),
        .result (load_val)
    );

    assign wb_rd = w_q.rd;
    // A misaligned instruction still occupies W but must never write the register file.
    assign wb_we = w_q.valid & w_q.reg_we & (w_q.rd != 5'd0) & ~w_q.mis;

`ifdef MISALIGN_FLAG_EN
    assign misalign = w_q.valid & w_q.mis;
`endif

    // Writeback source mux; the unused encoding returns zero.
    always_comb begin
        case (w_q.wb_sel)
            WB_SEL_ALU:  wb_data = w_q.alu_out;
            WB_SEL_LOAD: wb_data = load_val;
            WB_SEL_PC4:  wb_data = w_q.pc_plus4;
            default:     wb_data = 32'd0;
        endcase
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter DMEM_AW, default 14, data-memory word-address width.
REQ-002 SHALL have clk  input  1  rising-edge clock; sole clock.
REQ-003 SHALL have rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have in_valid  input  1  execute-stage result valid this cycle.
REQ-005 SHALL have stall  input  1  hold stage; no new capture, no memory request.
REQ-006 SHALL have flush  input  1  kill incoming instruction.
REQ-007 SHALL have alu_out  input  32  ALU result; memory byte address for loads/stores.
REQ-008 SHALL have rs2_data  input  32  store data.
REQ-009 SHALL have pc_plus4  input  32  link value for JAL/JALR.
REQ-010 SHALL have rd  input  5; reg_we  input  1; mem_rd  input  1; mem_wr  input  1; funct3  input  3; wb_sel  input  2 (0 ALU, 1 load, 2 pc+4).
REQ-011 SHALL have dmem_en  output  1; dmem_we  output  4; dmem_addr  output  DMEM_AW; dmem_din  output  32; dmem_dout  input  32 (synchronous read, 1-cycle latency).
REQ-012 SHALL have wb_we  output  1; wb_rd  output  5; wb_data  output  32 (to register file and forwarding).
REQ-013 SHALL have misalign  output  1  (only with MISALIGN_FLAG_EN).

Function
REQ-014 Issue condition "go" SHALL be in_valid & !stall & !flush.
REQ-015 dmem_en SHALL equal go & (mem_rd | mem_wr), combinational; dmem_addr SHALL be alu_out[DMEM_AW+1:2].
REQ-016 dmem_we SHALL be 0 unless go & mem_wr; SB: 4'b0001<<alu_out[1:0]; SH: 4'b0011<<{alu_out[1],1'b0}; SW: 4'b1111.
REQ-017 dmem_din SHALL be rs2_data shifted left by 8*alu_out[1:0] (SB) or 16*alu_out[1] (SH), unshifted for SW.
REQ-018 On each rising edge with go, the W register SHALL capture valid=1, rd, reg_we, wb_sel, funct3, alu_out, pc_plus4.
REQ-019 On an edge with stall=1 and flush=0, the W register SHALL hold all fields.
REQ-020 On an edge with flush=1 (stall ignored) or in_valid=0 & stall=0, W.valid SHALL become 0.
REQ-021 Load extraction SHALL use W.funct3 and W.alu_out[1:0] on dmem_dout: LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-022 wb_data SHALL be W.alu_out, extracted load, or W.pc_plus4 per W.wb_sel; wb_sel=3 SHALL give 0.
REQ-023 wb_we SHALL equal W.valid & W.reg_we & (W.rd != 0); wb_rd SHALL equal W.rd.
REQ-024 While stalled with a load in W, upstream SHALL keep dmem_en=0 so dmem_dout stays unchanged; block adds no extra read buffering.
REQ-025 Latency: memory request same cycle as input; writeback one cycle later.

Reset
REQ-026 rst SHALL asynchronously clear W.valid and all W fields to 0; wb_we=0, wb_data=0, wb_rd=0, misalign=0 during reset.
REQ-027 dmem_en and dmem_we SHALL be 0 while rst=1 regardless of inputs.
REQ-028 Reset asserted mid-store SHALL suppress that store combinationally.

Configuration
REQ-029 Macro MISALIGN_FLAG_EN SHALL, when defined, detect halfword access with alu_out[0]=1 or word access with alu_out[1:0]!=0, force dmem_en=0/dmem_we=0, register misalign=1 for one cycle, and force wb_we=0 for that instruction.
REQ-030 Without MISALIGN_FLAG_EN the misalign port SHALL be absent and misaligned accesses SHALL proceed using the masks above without checking.

Structure
REQ-031 wb_sel encodings and funct3 load/store codes SHALL live in the shared core package with the ALU select codes.
REQ-032 Load extraction SHALL be a sub-module load_extract (combinational, funct3+offset+word -> 32-bit result).

Verification
REQ-033 SB rs2=0x000000AB, alu_out=0x103 -> dmem_we=4'b1000, dmem_din=0xAB000000, dmem_addr=0x40.
REQ-034 LB at alu_out=0x2 with dmem_dout=0x00800000 next cycle -> wb_data=0xFFFFFF80; LBU -> 0x00000080.
REQ-035 JAL rd=1, pc_plus4=0x1004, wb_sel=2 -> wb_we=1, wb_data=0x1004 one cycle later; rd=0 -> wb_we=0.
REQ-036 Store with flush=1 -> dmem_we=0; next cycle wb_we=0; stall=1 for 3 cycles -> W fields held, dmem_en=0.
REQ-037 rst pulsed between edges while W.valid=1 -> wb_we falls immediately without clock edge.
REQ-038 With MISALIGN_FLAG_EN: LW at alu_out=0x6 -> dmem_en=0, misalign=1 next cycle, wb_we=0.
